// File: rtl/twiddle_pkg.sv
// Shared types and constants for the twiddle fetch sequencer and its output FIFO.
package twiddle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } twf_state_e;

  localparam int TWF_FIFO_DEPTH = 4;
  localparam int TWF_TW_W       = 16;
  localparam int TWF_PTR_W      = $clog2(TWF_FIFO_DEPTH);
  localparam int TWF_CNT_W      = TWF_PTR_W + 1;

  // Words buffered plus words still travelling through the address/ROM stages.
  function automatic logic [TWF_CNT_W-1:0] twf_occupancy(
    input logic [TWF_CNT_W-1:0] fifo_cnt,
    input logic                 issue_vld,
    input logic                 rom_vld
  );
    return fifo_cnt + TWF_CNT_W'(issue_vld) + TWF_CNT_W'(rom_vld);
  endfunction

endpackage

// File: rtl/twf_out_fifo.sv
// 4-entry synchronous FIFO holding twiddle word, ROM index and last flag.
module twf_out_fifo
  import twiddle_pkg::*;
#(
  parameter int DW = TWF_TW_W,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DW-1:0]        wr_data,
  input  logic [AW-1:0]        wr_index,
  input  logic                 wr_last,
  input  logic                 rd_en,
  output logic [DW-1:0]        rd_data,
  output logic [AW-1:0]        rd_index,
  output logic                 rd_last,
  output logic                 empty,
  output logic [TWF_CNT_W-1:0] count
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } ent_t;

  localparam logic [TWF_CNT_W-1:0] CAP = TWF_CNT_W'(TWF_FIFO_DEPTH);

  ent_t                 mem_q [TWF_FIFO_DEPTH];
  ent_t                 head;
  logic [TWF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TWF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TWF_CNT_W-1:0] count_q, count_d;
  logic                 do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    do_wr    = wr_en && ((count_q != CAP) || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + TWF_PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + TWF_PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + TWF_CNT_W'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - TWF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= '{data: wr_data, idx: wr_index, last: wr_last};
    end
  end

  // Storage is not reset; the head is gated so outputs read zero while empty.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    empty    = (count_q == '0);
    rd_data  = empty ? '0 : head.data;
    rd_index = empty ? '0 : head.idx;
    rd_last  = empty ? 1'b0 : head.last;
    count    = count_q;
  end

endmodule

// File: rtl/twiddle_fetch_seq.sv
// Streams DEPTH twiddle words from a 1-cycle-latency ROM into a ready/valid port.
// Optional TWF_LOOP_EN adds a loop input that restarts at address 0 without draining.
module twiddle_fetch_seq
  import twiddle_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = TWF_TW_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef TWF_LOOP_EN
  input  logic          loop,
`endif
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] tw_data,
  output logic [AW-1:0] tw_index,
  output logic          tw_valid,
  input  logic          tw_ready,
  output logic          tw_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0]        LAST_IDX = AW'(DEPTH - 1);
  localparam logic [TWF_CNT_W-1:0] CAP      = TWF_CNT_W'(TWF_FIFO_DEPTH);

  twf_state_e           state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 issue_vld_q, issue_vld_d;
  logic                 rom_vld_q, rom_vld_d;
  logic [AW-1:0]        rom_idx_q, rom_idx_d;
  logic                 done_q, done_d;
  logic                 loop_en;
  logic                 can_issue;
  logic                 final_xfer;
  logic [TWF_CNT_W-1:0] fifo_count;
  logic                 fifo_empty;

`ifdef TWF_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  // Issuing only while total occupancy < 4 reserves a FIFO slot for every in-flight read.
  assign can_issue  = twf_occupancy(fifo_count, issue_vld_q, rom_vld_q) < CAP;
  // The very last word is the only one left anywhere once nothing is in flight.
  assign final_xfer = tw_valid && tw_ready && tw_last && (fifo_count == TWF_CNT_W'(1))
                      && !issue_vld_q && !rom_vld_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_vld_d = 1'b0;
    done_d      = 1'b0;
    rom_vld_d   = issue_vld_q;
    rom_idx_d   = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = '0;
          issue_vld_d = 1'b1;
          state_d     = ((LAST_IDX == '0) && !loop_en) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (can_issue) begin
          addr_d      = (addr_q == LAST_IDX) ? '0 : addr_q + AW'(1);
          issue_vld_d = 1'b1;
          if ((addr_d == LAST_IDX) && !loop_en) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (final_xfer) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      issue_vld_q <= 1'b0;
      rom_vld_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_vld_q <= issue_vld_d;
      rom_vld_q   <= rom_vld_d;
      done_q      <= done_d;
    end
  end

  // ROM stage: index travels with the read so it lines up with rom_data.
  always_ff @(posedge clk) begin
    rom_idx_q <= rom_idx_d;
  end

  twf_out_fifo #(
    .DW(DW),
    .AW(AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (rom_vld_q),
    .wr_data  (rom_data),
    .wr_index (rom_idx_q),
    .wr_last  (rom_idx_q == LAST_IDX),
    .rd_en    (tw_valid && tw_ready),
    .rd_data  (tw_data),
    .rd_index (tw_index),
    .rd_last  (tw_last),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign tw_valid = !fifo_empty;
  assign rom_addr = addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_twiddle_fetch_seq.sv
// Randomized bench for twiddle_fetch_seq with a queue-based transfer model.
module tb_twiddle_fetch_seq;

  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
    logic          fin;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          tw_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] tw_data;
  logic [AW-1:0] tw_index;
  logic          tw_valid;
  logic          tw_last;
  logic          busy;
  logic          done;
`ifdef TWF_LOOP_EN
  logic          loop = 1'b0;
`endif

  logic [DW-1:0] rom [0:31];
  logic [DW-1:0] got_data [0:31];
  exp_t          q[$];
  int            last_pos[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            xfer_cnt = 0;
  int            last_cnt = 0;
  bit            exp_done = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic          prev_last;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  twiddle_fetch_seq #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef TWF_LOOP_EN
    .loop     (loop),
`endif
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .tw_data  (tw_data),
    .tw_index (tw_index),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .tw_last  (tw_last),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One run's worth of expected transfers, straight from the ROM contents.
  task automatic push_run(input bit fin);
    for (int i = 0; i < DEPTH; i++) begin
      q.push_back('{idx: AW'(i), data: rom[i], last: (i == DEPTH - 1), fin: fin && (i == DEPTH - 1)});
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 32; i++) rom[i] = DW'($urandom);
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit rnd_ready, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
      else if (rnd_ready) tw_ready = 1'($urandom_range(0, 1));
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, 32'(tw_valid), 32'd0);
    chk({tag, "_data"},  32'(tw_data),  32'd0);
    chk({tag, "_index"}, 32'(tw_index), 32'd0);
    chk({tag, "_last"},  32'(tw_last),  32'd0);
    chk({tag, "_busy"},  32'(busy),     32'd0);
    chk({tag, "_done"},  32'(done),     32'd0);
    chk({tag, "_addr"},  32'(rom_addr), 32'd0);
  endtask

  // Per-cycle compare against the expected-transfer queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) chk("busy_in_done", 32'(busy), 32'd0);
      if (prev_stall) begin
        chk("hold_valid", 32'(tw_valid), 32'd1);
        chk("hold_data",  32'(tw_data),  32'(prev_data));
        chk("hold_index", 32'(tw_index), 32'(prev_idx));
        chk("hold_last",  32'(tw_last),  32'(prev_last));
      end
      exp_done = 1'b0;
      if (tw_valid && tw_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_xfer: index %0d data 0x%0h with nothing expected", tw_index, tw_data);
        end else begin
          e = q.pop_front();
          chk("xfer_index", 32'(tw_index), 32'(e.idx));
          chk("xfer_data",  32'(tw_data),  32'(e.data));
          chk("xfer_last",  32'(tw_last),  32'(e.last));
          exp_done = e.fin;
        end
        got_data[tw_index] = tw_data;
        if (tw_last) begin
          last_pos.push_back(xfer_cnt);
          last_cnt++;
        end
        xfer_cnt++;
      end
      prev_stall = tw_valid && !tw_ready;
      prev_data  = tw_data;
      prev_idx   = tw_index;
      prev_last  = tw_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int base_last;
    bit reached;

    fill_rom();
    #1 rst = 1'b1;
    #20;
    chk_idle_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Basic run with pinned ROM words.
    fill_rom();
    rom[0]  = 16'h0100;
    rom[9]  = 16'h00B5;
    rom[24] = 16'h00FB;
    tw_ready = 1'b1;
    base = xfer_cnt;
    base_last = last_cnt;
    push_run(1'b1);
    start_pulse();
    chk("e0_addr", 32'(rom_addr), 32'd0);
    chk("e0_busy", 32'(busy), 32'd1);
    chk("e0_valid", 32'(tw_valid), 32'd0);
    @(posedge clk); #1;
    chk("e1_valid", 32'(tw_valid), 32'd0);
    @(posedge clk); #1;
    chk("e2_valid", 32'(tw_valid), 32'd1);
    chk("e2_index", 32'(tw_index), 32'd0);
    chk("e2_data", 32'(tw_data), 32'h0100);
    wait_done(100, 1'b0, cyc);
    chk("run_cycles_to_done", 32'(cyc + 2), 32'd30);
    chk("run_xfers", 32'(xfer_cnt - base), 32'd28);
    chk("run_lasts", 32'(last_cnt - base_last), 32'd1);
    chk("data_at_0", 32'(got_data[0]), 32'h0100);
    chk("data_at_9", 32'(got_data[9]), 32'h00B5);
    chk("data_at_24", 32'(got_data[24]), 32'h00FB);
    chk("run_queue_empty", 32'(q.size()), 32'd0);

    // Backpressure right after start.
    fill_rom();
    tw_ready = 1'b0;
    push_run(1'b1);
    start_pulse();
    repeat (9) @(posedge clk);
    #1;
    chk("bp_addr", 32'(rom_addr), 32'd3);
    chk("bp_valid", 32'(tw_valid), 32'd1);
    chk("bp_index", 32'(tw_index), 32'd0);
    tw_ready = 1'b1;
    wait_done(200, 1'b0, cyc);
    chk("bp_queue_empty", 32'(q.size()), 32'd0);

    // Random ready over several runs.
    for (int r = 0; r < 3; r++) begin
      fill_rom();
      base = xfer_cnt;
      push_run(1'b1);
      start_pulse();
      wait_done(400, 1'b1, cyc);
      chk("rnd_xfers", 32'(xfer_cnt - base), 32'd28);
      chk("rnd_queue_empty", 32'(q.size()), 32'd0);
    end

    // Reset in the middle of a run.
    @(posedge clk); #1 tw_ready = 1'b1;
    fill_rom();
    base = xfer_cnt;
    push_run(1'b1);
    start_pulse();
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk); #1;
      if (xfer_cnt >= base + 5) reached = 1'b1;
    end
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL rst_wait_timeout: transfers %0d, needed 5", xfer_cnt - base);
    end
    rst = 1'b1;
    #1;
    chk_idle_zero("midrst");
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_valid", 32'(tw_valid), 32'd0);
    fill_rom();
    push_run(1'b1);
    start_pulse();
    repeat (2) @(posedge clk);
    #1;
    chk("postrst_first_index", 32'(tw_index), 32'd0);
    wait_done(100, 1'b0, cyc);
    chk("postrst_queue_empty", 32'(q.size()), 32'd0);

    // Start held high: back-to-back runs.
    fill_rom();
    push_run(1'b1);
    push_run(1'b1);
    @(posedge clk); #1 start = 1'b1;
    wait_done(100, 1'b0, cyc);
    chk("b2b_queue_mid", 32'(q.size()), 32'd28);
    @(posedge clk); #1 start = 1'b0;
    chk("b2b_restart_busy", 32'(busy), 32'd1);
    chk("b2b_restart_addr", 32'(rom_addr), 32'd0);
    wait_done(100, 1'b0, cyc);
    chk("b2b_period", 32'(cyc), 32'd30);
    chk("b2b_queue_empty", 32'(q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_idle_valid", 32'(tw_valid), 32'd0);
    chk("b2b_idle_busy", 32'(busy), 32'd0);

`ifdef TWF_LOOP_EN
    // Looping: two looped runs then a final one.
    fill_rom();
    base = xfer_cnt;
    base_last = last_cnt;
    last_pos.delete();
    push_run(1'b0);
    push_run(1'b0);
    push_run(1'b1);
    loop = 1'b1;
    start_pulse();
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(posedge clk); #1;
      if (last_cnt >= base_last + 2) reached = 1'b1;
    end
    loop = 1'b0;
    wait_done(200, 1'b0, cyc);
    chk("loop_xfers", 32'(xfer_cnt - base), 32'd84);
    chk("loop_lasts", 32'(last_pos.size()), 32'd3);
    if (last_pos.size() == 3) begin
      chk("loop_last0", 32'(last_pos[0] - base), 32'd27);
      chk("loop_last1", 32'(last_pos[1] - base), 32'd55);
      chk("loop_last2", 32'(last_pos[2] - base), 32'd83);
    end
    chk("loop_queue_empty", 32'(q.size()), 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
